table_fsm: RTL and testbench
============================

TABLE_FSM -- requirements
Module: table_fsm

Interface
- REQ-001: Parameter SW, default 3, state-register width in bits.
- REQ-002: Parameter IW, default 1, input-symbol width in bits.
- REQ-003: Parameter OW, default 3, output-code width in bits.
- REQ-004: Parameter RESET_STATE, default 3'd2, state loaded on reset.
- REQ-005: Parameter RESET_OUT, default 0, output code loaded on reset.
- REQ-006: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-007: reset  input  1  one clock; reset is synchronous and active-high.
- REQ-008: a  input  IW  input symbol sampled on each step.
- REQ-009: run  input  1  level; 1 allows stepping, 0 halts the machine.
- REQ-010: step_en  input  1  qualifies one transition per cycle while running.
- REQ-011: wr_valid  input  1  table-write request.
- REQ-012: wr_ready  output  1  table-write accept.
- REQ-013: wr_addr  input  SW+IW  table index, formed as {state, a}.
- REQ-014: wr_data  input  SW+OW  entry, formed as {next_state, out_code}.
- REQ-015: saida  output  OW  registered output code.
- REQ-016: state_o  output  SW  current state.
- REQ-017: busy  output  1  high while the table clear is in progress.

Function
- REQ-018: Table depth SHALL be 2^(SW+IW) entries of SW+OW bits, with asynchronous read and synchronous write.
- REQ-019: Control SHALL use three modes: CLEAR -> IDLE when the clear completes; IDLE -> RUN when run=1; RUN -> IDLE when run=0.
- REQ-020: In CLEAR, one entry per cycle SHALL be written to {RESET_STATE, RESET_OUT}, from address 0 up to depth-1; busy=1 for exactly 2^(SW+IW) cycles.
- REQ-021: A step SHALL occur in a cycle with mode RUN and step_en=1. On that edge, state_o <= entry[{state_o,a}].next_state and saida <= entry.out_code, giving 1-cycle latency.
- REQ-022: With no step (IDLE, CLEAR, or step_en=0), state_o and saida SHALL hold.
- REQ-023: wr_ready SHALL equal !busy; a write occurs when wr_valid and wr_ready are both 1, and takes effect on that edge.
- REQ-024: Writes SHALL be accepted in IDLE and in RUN.
- REQ-025: If a write and a step address the same entry in the same cycle, the step SHALL use the old contents (read-before-write).
- REQ-026: State codes not present in the table path SHALL still index the table; there are no illegal-state traps.

Reset
- REQ-027: Reset SHALL set state_o=RESET_STATE, saida=RESET_OUT, mode=CLEAR and clear address=0.
- REQ-028: Reset asserted mid-clear or mid-run SHALL restart the full clear sequence.
- REQ-029: Writes presented during reset or CLEAR SHALL be dropped and not retained.

Configuration
- REQ-030: Macro TABLE_FSM_TRANS_CNT_EN, when defined, SHALL add output trans_cnt (16 bits).
- REQ-031: trans_cnt SHALL be cleared by reset, incremented on each step whose next_state differs from state_o, and saturate at 16'hFFFF.
- REQ-032: Without TABLE_FSM_TRANS_CNT_EN, the trans_cnt port and its logic SHALL be absent, with no other behavioural change.

Structure
- REQ-033: Package table_fsm_pkg SHALL hold the mode enum (CLEAR, IDLE, RUN) and the default SW/IW/OW constants.
- REQ-034: Table storage SHALL be sub-module table_fsm_mem (1 write port, 1 async read port, parametrised width and depth).
- REQ-035: Mode control, clear counter and output registers SHALL live in table_fsm.

Verification (defaults: SW=3, IW=1, OW=3, depth 16)
- REQ-036: Reset pulse of 1 cycle -> busy=1 for 16 cycles then 0; state_o=2, saida=0 throughout; all entries read 6'd16.
- REQ-037: Write addr 4 with data 6'd36, then run=1, step_en=1, a=0 -> after 1 edge state_o=4, saida=4.
- REQ-038: Program entries {4,1}=6'd54 and {6,0}=6'd60; with a=1 then a=0 -> state_o steps 4->6->7, saida 6 then 4.
- REQ-039: Same-cycle write to addr 4 (6'd9) and a step from state 2 with a=0 -> next state comes from the old entry; the following step from state 2 uses 6'd9.
- REQ-040: step_en=0 or run=0 for 5 cycles -> state_o and saida unchanged.
- REQ-041: Reset mid-RUN -> state_o=2, busy=1 for 16 cycles, previously programmed entries cleared; with TABLE_FSM_TRANS_CNT_EN, trans_cnt=0 and a forced count to 16'hFFFF stays at 16'hFFFF.

Source files
------------

// File: rtl/table_fsm_pkg.sv
// Shared types and default geometry for the table-driven state machine.
package table_fsm_pkg;

  localparam int DEF_SW = 3;
  localparam int DEF_IW = 1;
  localparam int DEF_OW = 3;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2
  } mode_t;

  function automatic int tbl_depth(input int sw, input int iw);
    return 2 ** (sw + iw);
  endfunction

endpackage

// File: rtl/table_fsm_if.sv
// Table-write handshake bus: index {state, a}, entry {next_state, out_code}.
interface table_fsm_if
  import table_fsm_pkg::*;
#(
  parameter int SW = DEF_SW,
  parameter int IW = DEF_IW,
  parameter int OW = DEF_OW
);
  logic              wr_valid;
  logic              wr_ready;
  logic [SW+IW-1:0]  wr_addr;
  logic [SW+OW-1:0]  wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/table_fsm_mem.sv
// Transition table storage: one synchronous write port, one asynchronous read port.
module table_fsm_mem #(
  parameter int AW = 4,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Combinational read returns pre-edge contents, so a same-cycle write is not seen.
  assign rdata = mem[raddr];
endmodule

// File: rtl/table_fsm.sv
// Table-driven Moore-style stepper with self-clearing transition table.
// Optional TABLE_FSM_TRANS_CNT_EN adds a saturating state-change counter output.
module table_fsm
  import table_fsm_pkg::*;
#(
  parameter int            SW          = DEF_SW,
  parameter int            IW          = DEF_IW,
  parameter int            OW          = DEF_OW,
  parameter logic [SW-1:0] RESET_STATE = SW'(2),
  parameter logic [OW-1:0] RESET_OUT   = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] a,
  input  logic          run,
  input  logic          step_en,
  table_fsm_if.slave    wr,
  output logic [OW-1:0] saida,
  output logic [SW-1:0] state_o,
  output logic          busy
`ifdef TABLE_FSM_TRANS_CNT_EN
  ,
  output logic [15:0]   trans_cnt
`endif
);
  localparam int AW    = SW + IW;
  localparam int DW    = SW + OW;
  localparam int DEPTH = tbl_depth(SW, IW);

  mode_t         mode, mode_nxt;
  logic [AW-1:0] clr_addr;
  logic          step;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rd_entry;
  logic [SW-1:0] rd_next;
  logic [OW-1:0] rd_out;

  assign busy        = (mode == CLEAR);
  assign wr.wr_ready = !busy;
  assign step        = (mode == RUN) && step_en;
  assign rd_next     = rd_entry[DW-1:OW];
  assign rd_out      = rd_entry[OW-1:0];

  // Clear sweep owns the write port; host writes in the reset cycle are dropped.
  assign mem_we    = !reset && (busy || (wr.wr_valid && wr.wr_ready));
  assign mem_waddr = busy ? clr_addr : wr.wr_addr;
  assign mem_wdata = busy ? {RESET_STATE, RESET_OUT} : wr.wr_data;

  table_fsm_mem #(.AW(AW), .DW(DW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr ({state_o, a}),
    .rdata (rd_entry)
  );

  always_comb begin
    mode_nxt = mode;
    case (mode)
      CLEAR:   if (clr_addr == AW'(DEPTH - 1)) mode_nxt = IDLE;
      IDLE:    if (run) mode_nxt = RUN;
      RUN:     if (!run) mode_nxt = IDLE;
      default: mode_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode     <= CLEAR;
      clr_addr <= '0;
      state_o  <= RESET_STATE;
      saida    <= RESET_OUT;
    end else begin
      mode <= mode_nxt;
      if (busy) clr_addr <= clr_addr + 1'b1;
      if (step) begin
        state_o <= rd_next;
        saida   <= rd_out;
      end
    end
  end

`ifdef TABLE_FSM_TRANS_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      trans_cnt <= '0;
    else if (step && (rd_next != state_o) && (trans_cnt != 16'hFFFF))
      trans_cnt <= trans_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_table_fsm.sv
// Self-checking bench for table_fsm: reference table model feeds an expected-result queue.
module tb_table_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [0:0] a = '0;
  logic       run = 1'b0;
  logic       step_en = 1'b0;
  logic [2:0] saida;
  logic [2:0] state_o;
  logic       busy;
`ifdef TABLE_FSM_TRANS_CNT_EN
  logic [15:0] trans_cnt;
`endif

  table_fsm_if #(.SW(3), .IW(1), .OW(3)) wr_bus ();

  table_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .run     (run),
    .step_en (step_en),
    .wr      (wr_bus),
    .saida   (saida),
    .state_o (state_o),
    .busy    (busy)
`ifdef TABLE_FSM_TRANS_CNT_EN
    ,
    .trans_cnt (trans_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] out;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] m_tbl [16];
  logic [2:0] m_state;
  logic [2:0] m_out;
  int         errors = 0;
  int         checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_tbl[i] = 6'd16;
    m_state = 3'd2;
    m_out   = 3'd0;
  endtask

  task automatic wr_entry(input logic [3:0] wa, input logic [5:0] wd);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = wa;
    wr_bus.wr_data  = wd;
    tick();
    wr_bus.wr_valid = 1'b0;
    m_tbl[wa] = wd;
  endtask

  // One step, optionally with a concurrent table write; expected result queued from the model.
  task automatic drive_step(input logic a_v, input logic wr_en,
                            input logic [3:0] wa, input logic [5:0] wd);
    logic [5:0] e;
    e = m_tbl[{m_state, a_v}];
    sb.push_back(exp_t'({e[5:3], e[2:0]}));
    a = a_v;
    step_en = 1'b1;
    wr_bus.wr_valid = wr_en;
    wr_bus.wr_addr  = wa;
    wr_bus.wr_data  = wd;
    tick();
    step_en = 1'b0;
    wr_bus.wr_valid = 1'b0;
    if (wr_en) m_tbl[wa] = wd;
    m_state = e[5:3];
    m_out   = e[2:0];
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
  endtask

  task automatic stop_run();
    run = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int cnt;
    int bad;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    checks++;
    if (busy !== 1'b1 || wr_bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b ready=%b, want busy=1 ready=0", busy, wr_bus.wr_ready);
    end
    // A write held across the whole clear must not land.
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = 4'd4;
    wr_bus.wr_data  = 6'd36;
    cnt = 0;
    bad = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (state_o !== 3'd2 || saida !== 3'd0) bad++;
      cnt++;
      tick();
    end
    wr_bus.wr_valid = 1'b0;
    checks++;
    if (cnt !== 16) begin
      errors++;
      $display("FAIL reset_busy_len: busy cycles=%0d, want 16", cnt);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_hold: %0d cycles with state/saida off reset value, want 0", bad);
    end
    checks++;
    if (wr_bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: wr_ready=%b, want 1", wr_bus.wr_ready);
    end
    start_run();
    for (int i = 0; i < 2; i++) begin
      exp_t x;
      drive_step(i[0], 1'b0, 4'd0, 6'd0);
      x = sb.pop_front();
      checks++;
      if (state_o !== x.st || saida !== x.out) begin
        errors++;
        $display("FAIL cleared_entry a=%0d: state=%0d saida=%0d, want %0d %0d",
                 i, state_o, saida, x.st, x.out);
      end
    end
    stop_run();
  endtask

  task automatic test_write_step();
    exp_t x;
    wr_entry(4'd4, 6'd36);
    start_run();
    drive_step(1'b0, 1'b0, 4'd0, 6'd0);
    x = sb.pop_front();
    checks++;
    if (state_o !== x.st || saida !== x.out || x !== exp_t'(6'd36)) begin
      errors++;
      $display("FAIL write_step: state=%0d saida=%0d, want 4 4", state_o, saida);
    end
    stop_run();
  endtask

  task automatic test_two_steps();
    wr_entry(4'd9, 6'd54);
    wr_entry(4'd12, 6'd60);
    start_run();
    drive_step(1'b1, 1'b0, 4'd0, 6'd0);
    drive_step(1'b0, 1'b0, 4'd0, 6'd0);
    stop_run();
    for (int i = 0; i < 2; i++) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (x !== (i == 0 ? exp_t'({3'd6, 3'd6}) : exp_t'({3'd7, 3'd4}))) begin
        errors++;
        $display("FAIL two_steps_model %0d: model %0d/%0d disagrees with 6/6,7/4", i, x.st, x.out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seen_s [4];
    logic [2:0] seen_o [4];
    wr_entry(4'd14, 6'd16);
    start_run();
    drive_step(1'b0, 1'b0, 4'd0, 6'd0);
    seen_s[0] = state_o; seen_o[0] = saida;
    drive_step(1'b0, 1'b1, 4'd4, 6'd9);
    seen_s[1] = state_o; seen_o[1] = saida;
    drive_step(1'b0, 1'b1, 4'd8, 6'd16);
    seen_s[2] = state_o; seen_o[2] = saida;
    drive_step(1'b0, 1'b0, 4'd0, 6'd0);
    seen_s[3] = state_o; seen_o[3] = saida;
    for (int i = 0; i < 4; i++) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (seen_s[i] !== x.st || seen_o[i] !== x.out) begin
        errors++;
        $display("FAIL rbw_step%0d: state=%0d saida=%0d, want %0d %0d",
                 i, seen_s[i], seen_o[i], x.st, x.out);
      end
    end
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    step_en = 1'b0;
    a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (state_o !== m_state || saida !== m_out) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_step_en0: %0d cycles moved, want 0 (state=%0d saida=%0d)", bad, state_o, saida);
    end
    stop_run();
    step_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (state_o !== m_state || saida !== m_out) bad++;
    end
    step_en = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_run0: %0d cycles moved, want 0 (state=%0d saida=%0d)", bad, state_o, saida);
    end
  endtask

  task automatic test_reset_mid_run();
    int cnt;
    exp_t x;
    wr_entry(4'd2, 6'd50);
    start_run();
    drive_step(1'b0, 1'b0, 4'd0, 6'd0);
    x = sb.pop_front();
    checks++;
    if (state_o !== x.st || saida !== x.out) begin
      errors++;
      $display("FAIL pre_reset_step: state=%0d saida=%0d, want %0d %0d", state_o, saida, x.st, x.out);
    end
    reset = 1'b1;
    run = 1'b0;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = 4'd4;
    wr_bus.wr_data  = 6'd36;
    tick();
    reset = 1'b0;
    wr_bus.wr_valid = 1'b0;
    model_clear();
    checks++;
    if (state_o !== 3'd2 || saida !== 3'd0) begin
      errors++;
      $display("FAIL midrun_reset_state: state=%0d saida=%0d, want 2 0", state_o, saida);
    end
`ifdef TABLE_FSM_TRANS_CNT_EN
    checks++;
    if (trans_cnt !== 16'd0) begin
      errors++;
      $display("FAIL trans_cnt_reset: trans_cnt=%0h, want 0", trans_cnt);
    end
`endif
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== 16) begin
      errors++;
      $display("FAIL midrun_busy_len: busy cycles=%0d, want 16", cnt);
    end
    start_run();
    for (int i = 0; i < 2; i++) begin
      drive_step(i[0], 1'b0, 4'd0, 6'd0);
      x = sb.pop_front();
      checks++;
      if (state_o !== x.st || saida !== x.out) begin
        errors++;
        $display("FAIL midrun_cleared a=%0d: state=%0d saida=%0d, want %0d %0d",
                 i, state_o, saida, x.st, x.out);
      end
    end
`ifdef TABLE_FSM_TRANS_CNT_EN
    checks++;
    if (trans_cnt !== 16'd0) begin
      errors++;
      $display("FAIL trans_cnt_selfloop: trans_cnt=%0h, want 0", trans_cnt);
    end
    drive_step(1'b0, 1'b1, 4'd4, 6'd36);
    void'(sb.pop_front());
    drive_step(1'b0, 1'b0, 4'd0, 6'd0);
    void'(sb.pop_front());
    checks++;
    if (trans_cnt !== 16'd1) begin
      errors++;
      $display("FAIL trans_cnt_inc: trans_cnt=%0h, want 1", trans_cnt);
    end
    force dut.trans_cnt = 16'hFFFF;
    tick();
    release dut.trans_cnt;
    wr_entry(4'd8, 6'd16);
    drive_step(1'b0, 1'b0, 4'd0, 6'd0);
    void'(sb.pop_front());
    checks++;
    if (trans_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL trans_cnt_sat: trans_cnt=%0h, want ffff", trans_cnt);
    end
`endif
    stop_run();
  endtask

  initial begin
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_addr  = '0;
    wr_bus.wr_data  = '0;
    model_clear();
    test_reset();
    test_write_step();
    test_two_steps();
    test_back_to_back();
    test_hold();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
